dat_mem_dma: RTL and testbench

//  Block-copy engine sitting directly upstream of the data memory; owns the memory's single port.

---
 rtl/dat_mem_dma.sv | 123 ++++++++++++
 tb/tb_dat_mem_dma.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/dat_mem_dma.sv
// ---------------------------------------------------------------------------
// dat_mem_dma
//   Block-copy engine in front of the data memory. It owns the memory's
//   single port. While idle, core loads and stores pass straight through.
//   After a start, it stalls the core and copies len bytes from src_addr to
//   dst_addr. Each byte takes two cycles: a read phase that uses the
//   memory's combinational read port, then a write phase.
//
// Ports
//   clk, rst_n                 clock; synchronous active-low reset
//   start, src_addr,           copy request. The address and length are
//   dst_addr, len              captured only when start is accepted in IDLE.
//   busy, core_stall           high while the copy is running (READ/WRITE)
//   done                       one-cycle pulse when a copy finishes
//   core_addr, core_dat_in,    core load/store port; used as the memory
//   core_wr_en                 request only in IDLE and DONE
//   core_dat_out               memory read data, returned to the core in
//                              every state
//   mem_addr, mem_dat_in,      memory port
//   mem_wr_en, mem_dat_out
// ---------------------------------------------------------------------------
module dat_mem_dma #(
    parameter int AW = 8,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [AW-1:0] src_addr,
    input  logic [AW-1:0] dst_addr,
    input  logic [AW-1:0] len,
    output logic          busy,
    output logic          done,
    output logic          core_stall,
    input  logic [AW-1:0] core_addr,
    input  logic [DW-1:0] core_dat_in,
    input  logic          core_wr_en,
    output logic [DW-1:0] core_dat_out,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_dat_in,
    output logic          mem_wr_en,
    input  logic [DW-1:0] mem_dat_out
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t        state, state_nxt;
    logic [AW-1:0] src_q, dst_q, len_q, idx;
    logic [DW-1:0] byte_buf;
    logic          wr_req;
    logic          last_byte;
    logic          accept;

    // A zero-length request skips the copy states and goes straight to DONE.
    // It does not latch the addresses or the length.
    assign accept    = (state == IDLE) && start && (len != '0);
    assign last_byte = (idx == len_q - AW'(1));

    // Next-state logic and the memory port mux
    always_comb begin
        state_nxt  = state;
        mem_addr   = core_addr;
        mem_dat_in = core_dat_in;
        wr_req     = core_wr_en;
        unique case (state)
            IDLE: begin
                if (start) state_nxt = (len != '0) ? READ : DONE;
            end
            READ: begin
                // The addition wraps modulo 2**AW, so a copy may run off the
                // top of memory.
                mem_addr  = src_q + idx;
                wr_req    = 1'b0;
                state_nxt = WRITE;
            end
            WRITE: begin
                mem_addr   = dst_q + idx;
                mem_dat_in = byte_buf;
                wr_req     = 1'b1;
                state_nxt  = last_byte ? DONE : READ;
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Gate the write strobe with reset, so nothing is written while reset is
    // held, even in the middle of a WRITE phase.
    assign mem_wr_en    = wr_req & rst_n;
    assign busy         = (state == READ) || (state == WRITE);
    assign core_stall   = busy;
    assign done         = (state == DONE);
    assign core_dat_out = mem_dat_out;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            idx      <= '0;
            byte_buf <= '0;
            src_q    <= '0;
            dst_q    <= '0;
            len_q    <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                src_q <= src_addr;
                dst_q <= dst_addr;
                len_q <= len;
                idx   <= '0;
            end
            if (state == READ) byte_buf <= mem_dat_out;
            if (state == WRITE && !last_byte) idx <= idx + AW'(1);
        end
    end

endmodule

// File: tb/tb_dat_mem_dma.sv
// ---------------------------------------------------------------------------
// tb_dat_mem_dma
//   Directed bench for dat_mem_dma. It contains a behavioural 256-byte
//   memory with a combinational read and a write on the clock edge. A
//   reference image models the memory contents. Each memory write the bench
//   expects is queued when the stimulus is driven, and is then matched
//   against the writes the DUT actually produces.
// ---------------------------------------------------------------------------
module tb_dat_mem_dma;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic [7:0] src_addr, dst_addr, len;
    logic       busy, done, core_stall;
    logic [7:0] core_addr, core_dat_in, core_dat_out;
    logic       core_wr_en;
    logic [7:0] mem_addr, mem_dat_in, mem_dat_out;
    logic       mem_wr_en;

    logic [7:0]  mem     [256];
    logic [7:0]  ref_mem [256];
    logic [15:0] exp_q   [$];
    logic [15:0] mon_e;
    int          checks   = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    dat_mem_dma #(.AW(8), .DW(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .src_addr(src_addr), .dst_addr(dst_addr), .len(len),
        .busy(busy), .done(done), .core_stall(core_stall),
        .core_addr(core_addr), .core_dat_in(core_dat_in), .core_wr_en(core_wr_en),
        .core_dat_out(core_dat_out),
        .mem_addr(mem_addr), .mem_dat_in(mem_dat_in), .mem_wr_en(mem_wr_en),
        .mem_dat_out(mem_dat_out)
    );

    function automatic logic [7:0] init_val(input int i);
        return 8'((i * 37 + 11) ^ (i >> 3));
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Memory model: preload, then the clocked write port
    assign mem_dat_out = mem[mem_addr];
    initial begin : mem_model
        for (int i = 0; i < 256; i++) mem[i] = init_val(i);
        mem[8'h10] = 8'hAA; mem[8'h11] = 8'hBB; mem[8'h12] = 8'hCC; mem[8'h13] = 8'hDD;
        mem[8'hFE] = 8'h01; mem[8'hFF] = 8'h02; mem[8'h00] = 8'h03;
        forever begin
            @(posedge clk);
            if (mem_wr_en === 1'b1) mem[mem_addr] <= mem_dat_in;
        end
    end

    // Scoreboard: every write the DUT issues must be the next expected one
    always @(negedge clk) begin
        if (mem_wr_en === 1'b1) begin
            check("write_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                check("write_addr_data", {16'h0, mem_addr, mem_dat_in}, {16'h0, mon_e});
            end
        end
    end

    // Runs one copy. The expected writes are queued up front. done must
    // appear 2*l cycles after the accepting edge.
    task automatic run_copy(input string tag, input logic [7:0] s, input logic [7:0] d,
                            input logic [7:0] l, input bit stray, input bit stall);
        int         k;
        bit         got;
        logic [7:0] a, b;
        for (int i = 0; i < int'(l); i++) begin
            a = s + 8'(i);
            b = d + 8'(i);
            ref_mem[b] = ref_mem[a];
            exp_q.push_back({b, ref_mem[b]});
        end
        start = 1'b1; src_addr = s; dst_addr = d; len = l;
        @(posedge clk); #1;
        start = 1'b0;
        src_addr = 8'($urandom); dst_addr = 8'($urandom); len = 8'($urandom);
        k = 0; got = 1'b0;
        while (k < 600) begin
            @(negedge clk);
            if (done === 1'b1) begin got = 1'b1; break; end
            check({tag, "_busy_stall"}, {30'h0, busy, core_stall}, 32'd3);
            @(posedge clk); #1;
            k++;
            start       = stray && (k == 1);
            core_wr_en  = stall && (k < 2 * int'(l));
            core_addr   = 8'h50;
            core_dat_in = 8'h77;
        end
        start = 1'b0; core_wr_en = 1'b0;
        check({tag, "_done_seen"}, 32'(got), 32'd1);
        check({tag, "_latency"}, k, 2 * int'(l));
        @(posedge clk); #1;
        @(negedge clk);
        check({tag, "_idle_after"}, {30'h0, busy, done}, 32'd0);
    endtask

    initial begin : stim
        int bad;
        for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
        ref_mem[8'h10] = 8'hAA; ref_mem[8'h11] = 8'hBB; ref_mem[8'h12] = 8'hCC; ref_mem[8'h13] = 8'hDD;
        ref_mem[8'hFE] = 8'h01; ref_mem[8'hFF] = 8'h02; ref_mem[8'h00] = 8'h03;

        // Reset is held with a core store pending; nothing may reach memory
        rst_n = 1'b0; start = 1'b0; src_addr = '0; dst_addr = '0; len = '0;
        core_addr = 8'h05; core_dat_in = 8'h99; core_wr_en = 1'b1;
        repeat (2) begin
            @(posedge clk); @(negedge clk);
            check("rst_mem_wr_en", 32'(mem_wr_en), 32'd0);
            check("rst_busy_done", {30'h0, busy, done}, 32'd0);
        end
        rst_n = 1'b1; core_wr_en = 1'b0;

        // Basic copy
        run_copy("basic", 8'h10, 8'h40, 8'd4, 1'b0, 1'b0);
        check("basic_dst", {mem[8'h40], mem[8'h41], mem[8'h42], mem[8'h43]}, 32'hAABBCCDD);
        check("basic_src", {mem[8'h10], mem[8'h11], mem[8'h12], mem[8'h13]}, 32'hAABBCCDD);
        core_addr = 8'h41;
        @(negedge clk);
        check("load_passthru", 32'(core_dat_out), 32'hBB);

        // The source range wraps from 0xFF back to 0x00
        run_copy("wrap", 8'hFE, 8'h20, 8'd3, 1'b0, 1'b0);
        check("wrap_dst", {8'h0, mem[8'h20], mem[8'h21], mem[8'h22]}, 32'h010203);

        // Zero-length copy, then a stray start issued while busy
        run_copy("len0", 8'h30, 8'h31, 8'd0, 1'b0, 1'b0);
        run_copy("stray", 8'h10, 8'h60, 8'd3, 1'b1, 1'b0);
        repeat (3) begin
            @(posedge clk); @(negedge clk);
            check("stray_stays_idle", {30'h0, busy, done}, 32'd0);
        end

        // A core store during the copy is dropped; the same store goes
        // through once the engine is idle again
        run_copy("stall", 8'h10, 8'h70, 8'd6, 1'b0, 1'b1);
        check("stall_no_write", 32'(mem[8'h50]), 32'(init_val(8'h50)));
        @(posedge clk); #1;
        exp_q.push_back({8'h50, 8'h77});
        ref_mem[8'h50] = 8'h77;
        core_wr_en = 1'b1; core_addr = 8'h50; core_dat_in = 8'h77;
        @(posedge clk); #1;
        core_wr_en = 1'b0;
        @(negedge clk);
        check("store_after_done", 32'(core_dat_out), 32'h77);

        // Overlapping copy with dst = src+1 replicates the first source byte
        run_copy("overlap", 8'h90, 8'h91, 8'd4, 1'b0, 1'b0);
        check("overlap_fill", {mem[8'h91], mem[8'h92], mem[8'h93], mem[8'h94]},
              {4{init_val(8'h90)}});

        // The destination range wraps from 0xFF back to 0x00
        run_copy("dst_wrap", 8'h05, 8'hFD, 8'd5, 1'b0, 1'b0);

        // Reset arrives during the fourth WRITE phase: only three bytes land
        for (int i = 0; i < 3; i++) begin
            ref_mem[8'hC0 + 8'(i)] = ref_mem[8'hA0 + 8'(i)];
            exp_q.push_back({8'hC0 + 8'(i), ref_mem[8'hC0 + 8'(i)]});
        end
        start = 1'b1; src_addr = 8'hA0; dst_addr = 8'hC0; len = 8'd8;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_wr_gated", 32'(mem_wr_en), 32'd0);
        repeat (2) begin
            @(posedge clk); @(negedge clk);
            check("midrst_idle", {30'h0, busy, done}, 32'd0);
        end
        rst_n = 1'b1;
        repeat (4) begin
            @(posedge clk); @(negedge clk);
            check("midrst_no_done", {30'h0, busy, done}, 32'd0);
        end

        // Final state: no expected write left over, and the memory matches
        check("queue_drained", exp_q.size(), 32'd0);
        bad = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) bad++;
        check("mem_image", bad, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
